// File: rtl/csr_ro_counters_if.sv
// Read-only CSR lookup bus between the CSR read/write file (master) and
// the counter/ID responder (slave). Address out, data and hit back, no handshake.
interface csr_ro_counters_if;
  logic [11:0] csr_ro_addr;
  logic [31:0] csr_ro_data;
  logic        csr_ro_hit;

  modport master (
    output csr_ro_addr,
    input  csr_ro_data,
    input  csr_ro_hit
  );

  modport slave (
    input  csr_ro_addr,
    output csr_ro_data,
    output csr_ro_hit
  );
endinterface

// File: rtl/csr_ro_counters.sv
// csr_ro_counters: 64-bit user counters (cycle, instret, optional time) and
// constant machine ID CSRs. Reads are a combinational mux of registered state.
// Optional feature macro: CSR_RO_TIME_EN builds the time prescaler and time_q
// and maps 0xC01/0xC81; without it those addresses miss and cnt_inhibit[1] is ignored.
module csr_ro_counters #(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] VENDOR_ID = 32'h0,
  parameter logic [31:0] ARCH_ID   = 32'h0,
  parameter logic [31:0] IMP_ID    = 32'h0,
  parameter int unsigned TIME_DIV  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  csr_ro_counters_if.slave         bus,
  input  logic                     instr_retire,
  input  logic [2:0]               cnt_inhibit
);

  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_TIME     = 12'hC01;
  localparam logic [11:0] A_TIMEH    = 12'hC81;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_INSTRETH = 12'hC82;
  localparam logic [11:0] A_VENDOR   = 12'hF11;
  localparam logic [11:0] A_ARCH     = 12'hF12;
  localparam logic [11:0] A_IMP      = 12'hF13;
  localparam logic [11:0] A_HART     = 12'hF14;

  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  logic [31:0] w_data;
  logic        w_hit;

  // cycle counter: counts every edge unless frozen by cnt_inhibit[0]
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle <= 64'h0;
    end else if (!cnt_inhibit[0]) begin
      r_cycle <= r_cycle + 64'd1;
    end
  end

  // instret counter: counts retired instructions unless frozen by cnt_inhibit[2]
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instret <= 64'h0;
    end else if (instr_retire && !cnt_inhibit[2]) begin
      r_instret <= r_instret + 64'd1;
    end
  end

`ifdef CSR_RO_TIME_EN
  // Prescaler wraps at TIME_DIV-1; TIME_DIV=1 makes the wrap fire every edge.
  localparam logic [15:0] DIV_LAST = 16'(TIME_DIV - 1);

  logic [15:0] r_presc;
  logic [63:0] r_time;

  // time prescaler and counter, both frozen by cnt_inhibit[1]
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= 16'h0;
      r_time  <= 64'h0;
    end else if (!cnt_inhibit[1]) begin
      if (r_presc == DIV_LAST) begin
        r_presc <= 16'h0;
        r_time  <= r_time + 64'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end
`else
  // No time counter is built, so the time inhibit bit has no consumer.
  logic w_unused_inh;
  assign w_unused_inh = cnt_inhibit[1];
`endif

  // read mux: zero-latency decode of the current register outputs
  always_comb begin
    w_data = 32'h0;
    w_hit  = 1'b0;
    case (bus.csr_ro_addr)
      A_CYCLE:    begin w_data = r_cycle[31:0];    w_hit = 1'b1; end
      A_CYCLEH:   begin w_data = r_cycle[63:32];   w_hit = 1'b1; end
      A_INSTRET:  begin w_data = r_instret[31:0];  w_hit = 1'b1; end
      A_INSTRETH: begin w_data = r_instret[63:32]; w_hit = 1'b1; end
`ifdef CSR_RO_TIME_EN
      A_TIME:     begin w_data = r_time[31:0];     w_hit = 1'b1; end
      A_TIMEH:    begin w_data = r_time[63:32];    w_hit = 1'b1; end
`endif
      A_VENDOR:   begin w_data = VENDOR_ID;        w_hit = 1'b1; end
      A_ARCH:     begin w_data = ARCH_ID;          w_hit = 1'b1; end
      A_IMP:      begin w_data = IMP_ID;           w_hit = 1'b1; end
      A_HART:     begin w_data = HART_ID;          w_hit = 1'b1; end
      default:    begin w_data = 32'h0;            w_hit = 1'b0; end
    endcase
  end

  assign bus.csr_ro_data = w_data;
  assign bus.csr_ro_hit  = w_hit;

endmodule

// File: tb/tb_csr_ro_counters.sv
// Self-checking bench for csr_ro_counters. Expected read results are queued
// when an address is driven and popped when the combinational response is sampled.
module tb_csr_ro_counters;

  localparam int unsigned TDIV = 4;

  logic       clock;
  logic       reset;
  logic       instr_retire;
  logic [2:0] cnt_inhibit;

  csr_ro_counters_if bus ();

  csr_ro_counters #(
    .HART_ID   (32'd5),
    .VENDOR_ID (32'h0000_0611),
    .ARCH_ID   (32'h0000_0022),
    .IMP_ID    (32'h0000_0333),
    .TIME_DIV  (TDIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .instr_retire (instr_retire),
    .cnt_inhibit  (cnt_inhibit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_err;

  // Reference state of the counters
  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic [63:0] m_time;
  int unsigned m_presc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cycle   = 64'h0;
    m_instret = 64'h0;
    m_time    = 64'h0;
    m_presc   = 0;
  endtask

  // Drive one cycle from a negedge, update the reference at the posedge.
  task automatic step(input logic retire, input logic [2:0] inh);
    instr_retire = retire;
    cnt_inhibit  = inh;
    @(posedge clock);
    if (!inh[0]) m_cycle = m_cycle + 64'd1;
    if (retire && !inh[2]) m_instret = m_instret + 64'd1;
    if (!inh[1]) begin
      if (m_presc == TDIV - 1) begin
        m_presc = 0;
        m_time  = m_time + 64'd1;
      end else begin
        m_presc = m_presc + 1;
      end
    end
    @(negedge clock);
    instr_retire = 1'b0;
    cnt_inhibit  = 3'b000;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr,
                    input logic [31:0] exp_data, input logic exp_hit);
    exp_t e;
    exp_t got;
    e.tag  = tag;
    e.data = exp_data;
    e.hit  = exp_hit;
    bus.csr_ro_addr = addr;
    q.push_back(e);
    #1;
    got = q.pop_front();
    chk({got.tag, "_data"}, {32'h0, bus.csr_ro_data}, {32'h0, got.data});
    chk({got.tag, "_hit"},  {63'h0, bus.csr_ro_hit},  {63'h0, got.hit});
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    instr_retire = 1'b0;
    cnt_inhibit  = 3'b000;
    bus.csr_ro_addr = 12'h000;
    model_reset();

    // Reset state, with the clock running
    @(negedge clock);
    @(negedge clock);
    rd("rst_cycle",   12'hC00, 32'h0, 1'b1);
    rd("rst_cycleh",  12'hC80, 32'h0, 1'b1);
    rd("rst_instret", 12'hC02, 32'h0, 1'b1);

    // Release and count 10 edges
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 3'b000);
    rd("cycle10",  12'hC00, 32'd10, 1'b1);
    rd("cycle10h", 12'hC80, 32'd0,  1'b1);

    // instret: 3 pulses in 5 cycles, second one inhibited
    step(1'b1, 3'b000);
    step(1'b0, 3'b000);
    step(1'b1, 3'b100);
    step(1'b0, 3'b000);
    step(1'b1, 3'b000);
    rd("instret2",  12'hC02, 32'd2, 1'b1);
    rd("instret2h", 12'hC82, 32'd0, 1'b1);
    rd("cycle15",   12'hC00, 32'd15, 1'b1);

    // Retire together with a read of 0xC02: pre-increment value, then new value
    instr_retire = 1'b1;
    rd("instret_pre", 12'hC02, 32'd2, 1'b1);
    step(1'b1, 3'b000);
    rd("instret_post", 12'hC02, 32'd3, 1'b1);

    // Cycle inhibit freezes, then resumes without catch-up
    for (int i = 0; i < 4; i++) step(1'b0, 3'b001);
    rd("cycle_frozen", 12'hC00, m_cycle[31:0], 1'b1);
    step(1'b0, 3'b000);
    rd("cycle_resume", 12'hC00, 32'd17, 1'b1);

    // Low-to-high carry in a single edge
    force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.r_cycle;
    m_cycle = 64'h0000_0000_FFFF_FFFF;
    step(1'b0, 3'b000);
    rd("carry_lo", 12'hC00, 32'h0, 1'b1);
    rd("carry_hi", 12'hC80, 32'h1, 1'b1);

    // Full 64-bit wrap to zero
    force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_cycle;
    m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1'b0, 3'b000);
    rd("wrap_lo", 12'hC00, 32'h0, 1'b1);
    rd("wrap_hi", 12'hC80, 32'h0, 1'b1);

    // Constant ID CSRs and an unmapped address
    rd("vendor",   12'hF11, 32'h0000_0611, 1'b1);
    rd("arch",     12'hF12, 32'h0000_0022, 1'b1);
    rd("imp",      12'hF13, 32'h0000_0333, 1'b1);
    rd("hart",     12'hF14, 32'd5,         1'b1);
    rd("unmapped", 12'h7C0, 32'h0,         1'b0);

    // Time counter from a fresh reset
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 13; i++) step(1'b0, 3'b000);
`ifdef CSR_RO_TIME_EN
    rd("time13", 12'hC01, 32'd3, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b010);
    rd("time_frozen",  12'hC01, 32'd3, 1'b1);
    rd("time_frozenh", 12'hC81, 32'd0, 1'b1);
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    rd("time_resume", 12'hC01, m_time[31:0], 1'b1);
`else
    rd("time_absent",  12'hC01, 32'h0, 1'b0);
    rd("timeh_absent", 12'hC81, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b010);
    rd("cycle_ign_inh1", 12'hC00, m_cycle[31:0], 1'b1);
`endif

    // 100 counts, then asynchronous reset mid-cycle
    for (int i = 0; i < 100; i++) step(1'b1, 3'b000);
    rd("pre_rst_cycle",   12'hC00, m_cycle[31:0],   1'b1);
    rd("pre_rst_instret", 12'hC02, m_instret[31:0], 1'b1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    rd("async_cycle",   12'hC00, 32'h0, 1'b1);
    rd("async_instret", 12'hC02, 32'h0, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 3'b000);
    rd("first_after_rst", 12'hC00, 32'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
